// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: runs one req/ack bus transaction per
// memory instruction, steers store lanes, extracts loads and drives pipe_en.
module mem_access_unit #(
  parameter int DATA_BITS   = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MemWrite_in,
  input  logic                 MemToReg_in,
  input  logic                 Sh_in,
  input  logic                 Sb_in,
  input  logic [1:0]           ExtrWord_in,
  input  logic                 ExtrSigned_in,
  input  logic                 Syscall_in,
  input  logic [DATA_BITS-1:0] addr_in,
  input  logic [DATA_BITS-1:0] wdata_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [DATA_BITS-1:0] dmem_addr,
  output logic [DATA_BITS-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [DATA_BITS-1:0] dmem_rdata,
  output logic [DATA_BITS-1:0] load_data,
  output logic                 load_valid,
  output logic                 pipe_en,
  output logic                 bus_err,
  output logic                 halted
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HALT} state_t;

  state_t      state;
  logic [CW-1:0] cnt;

  logic        access, is_byte, is_half, misalign;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ext_data;

  assign access = MemWrite_in | MemToReg_in;

  // Access size comes from the store flags for stores, ExtrWord for loads.
  always_comb begin
    is_byte  = MemWrite_in ? Sb_in : (ExtrWord_in == 2'b10);
    is_half  = MemWrite_in ? (Sh_in & ~Sb_in) : (ExtrWord_in == 2'b01);
    misalign = (is_half & addr_in[0]) | (~is_byte & ~is_half & (addr_in[1:0] != 2'b00));
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata_in;
    if (Sb_in) begin
      st_be    = 4'b0001 << addr_in[1:0];
      st_wdata = {4{wdata_in[7:0]}};
    end else if (Sh_in) begin
      st_be    = addr_in[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{wdata_in[15:0]}};
    end
  end

  always_comb begin
    half_sel = addr_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (addr_in[1:0])
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    case (ExtrWord_in)
      2'b01:   ext_data = {{16{ExtrSigned_in & half_sel[15]}}, half_sel};
      2'b10:   ext_data = {{24{ExtrSigned_in & byte_sel[7]}}, byte_sel};
      default: ext_data = dmem_rdata;
    endcase
  end

  assign pipe_en = ((state == IDLE) & ~access & ~Syscall_in) | (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Syscall_in) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (access) begin
            if (misalign) begin
              state      <= DONE;
              bus_err    <= 1'b1;
              load_data  <= '0;
              load_valid <= 1'b0;
            end else begin
              state      <= BUSY;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite_in;
              dmem_addr  <= {addr_in[DATA_BITS-1:2], 2'b00};
              dmem_be    <= MemWrite_in ? st_be : 4'b1111;
              dmem_wdata <= st_wdata;
            end
          end
        end
        BUSY: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              load_data  <= ext_data;
              load_valid <= 1'b1;
            end
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state      <= DONE;
            dmem_req   <= 1'b0;
            bus_err    <= 1'b1;
            load_data  <= '0;
            load_valid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          load_valid <= 1'b0;
        end
        default: begin
          state    <= HALT;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, random accesses
// against a byte-level reference model, and hand-written corner sequences.
module tb_mem_access_unit;

  logic        clk = 0, rst_n;
  logic        MemWrite_in, MemToReg_in, Sh_in, Sb_in, ExtrSigned_in, Syscall_in;
  logic [1:0]  ExtrWord_in;
  logic [31:0] addr_in, wdata_in, dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic        dmem_req, dmem_we, dmem_ack, load_valid, pipe_en, bus_err, halted;
  logic [3:0]  dmem_be;

  mem_access_unit #(.DATA_BITS(32), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
    .Sh_in(Sh_in), .Sb_in(Sb_in), .ExtrWord_in(ExtrWord_in), .ExtrSigned_in(ExtrSigned_in),
    .Syscall_in(Syscall_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .load_valid(load_valid), .pipe_en(pipe_en),
    .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  // ack_n: BUSY cycle on which ack is raised; 0 = never, -1 = misaligned (no bus cycle)
  typedef struct {
    logic mw, mr, sh, sb, es;
    logic [1:0] ew;
    logic [31:0] addr, wdata, rdata;
    int ack_n;
    logic [3:0] be;
    logic [31:0] exp_wdata, ld;
    logic err;
  } vec_t;

  int checks = 0, errors = 0;
  logic [31:0] exp_ld = 0;
  logic exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mw, mr, sh, sb, input logic [1:0] ew, input logic es,
                              input logic [31:0] addr, wdata, rdata, input int ack_n,
                              input logic [3:0] be, input logic [31:0] xw, ld, input logic err);
    vec_t v;
    v.mw = mw; v.mr = mr; v.sh = sh; v.sb = sb; v.ew = ew; v.es = es;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_n = ack_n;
    v.be = be; v.exp_wdata = xw; v.ld = ld; v.err = err;
    return v;
  endfunction

  // Reference model: access size in bytes, then lanes/extraction by arithmetic.
  function automatic int size_of(input vec_t v);
    if (v.mw) return v.sb ? 1 : (v.sh ? 2 : 4);
    return (v.ew == 2'b10) ? 1 : (v.ew == 2'b01) ? 2 : 4;
  endfunction

  function automatic vec_t model(input vec_t v);
    int sz = size_of(v);
    int off = int'(v.addr[1:0]);
    longint val;
    v.be = 4'(((1 << sz) - 1) << off);
    if (sz == 1)      v.exp_wdata = {4{v.wdata[7:0]}};
    else if (sz == 2) v.exp_wdata = {2{v.wdata[15:0]}};
    else              v.exp_wdata = v.wdata;
    val = (longint'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if (v.es && val >= (64'd1 << (8 * sz - 1))) val = val - (64'd1 << (8 * sz));
    v.ld = val[31:0];
    v.err = 0;
    return v;
  endfunction

  task automatic clear_inputs();
    MemWrite_in = 0; MemToReg_in = 0; Sh_in = 0; Sb_in = 0; ExtrWord_in = 0;
    ExtrSigned_in = 0; Syscall_in = 0; addr_in = 0; wdata_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Called just after a negedge with the unit in IDLE.
  task automatic run(input string nm, input vec_t v);
    bit is_load = v.mr & ~v.mw;
    bit done = 0;
    int low, busy = 0, cyc = 0, exp_busy;
    MemWrite_in = v.mw; MemToReg_in = v.mr; Sh_in = v.sh; Sb_in = v.sb;
    ExtrWord_in = v.ew; ExtrSigned_in = v.es; addr_in = v.addr; wdata_in = v.wdata;
    dmem_rdata = v.rdata;
    #1;
    chk({nm, " pipe_en_decode"}, 64'(pipe_en), 64'(0));
    low = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dmem_req) begin
        busy++; low++;
        chk({nm, " bus_ctl"}, {dmem_we, dmem_be, dmem_addr}, {v.mw, (is_load ? 4'hF : v.be), v.addr & ~32'h3});
        if (!is_load) chk({nm, " bus_wdata"}, 64'(dmem_wdata), 64'(v.exp_wdata));
        dmem_ack = (busy == v.ack_n);
      end else if (pipe_en) begin
        done = 1;
      end else begin
        low++;
      end
    end
    dmem_ack = 0;
    if (!done) chk({nm, " reach_done"}, 64'(0), 64'(1));
    exp_busy = (v.ack_n < 0) ? 0 : (v.ack_n == 0 || v.ack_n > 64) ? 64 : v.ack_n;
    if (v.err) exp_ld = 0; else if (is_load) exp_ld = v.ld;
    exp_err |= v.err;
    chk({nm, " stall_cycles"}, 64'(low), 64'(exp_busy + 1));
    chk({nm, " load_valid"}, 64'(load_valid), 64'(is_load && !v.err));
    chk({nm, " load_data"}, 64'(load_data), 64'(exp_ld));
    chk({nm, " bus_err"}, 64'(bus_err), 64'(exp_err));
    clear_inputs();
    @(negedge clk);
    chk({nm, " load_valid_drop"}, {load_valid, pipe_en, dmem_req}, {1'b0, 1'b1, 1'b0});
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    tbl[0]  = mk(1,0,0,0,2'b00,0, 32'h1004, 32'hDEADBEEF, 0, 2, 4'hF, 32'hDEADBEEF, 0, 0);
    tbl[1]  = mk(1,0,0,1,2'b00,0, 32'h2003, 32'h000000A5, 0, 1, 4'h8, 32'hA5A5A5A5, 0, 0);
    tbl[2]  = mk(0,1,0,0,2'b10,1, 32'h2002, 0, 32'h12805634, 1, 4'hF, 0, 32'hFFFFFF80, 0);
    tbl[3]  = mk(0,1,0,0,2'b10,0, 32'h2002, 0, 32'h12805634, 2, 4'hF, 0, 32'h00000080, 0);
    tbl[4]  = mk(0,1,0,0,2'b01,0, 32'h3002, 0, 32'hBEEF1234, 1, 4'hF, 0, 32'h0000BEEF, 0);
    tbl[5]  = mk(1,0,1,0,2'b00,0, 32'h1002, 32'h1234ABCD, 0, 3, 4'hC, 32'hABCDABCD, 0, 0);
    tbl[6]  = mk(0,1,0,0,2'b00,0, 32'h4000, 0, 32'h89ABCDEF, 1, 4'hF, 0, 32'h89ABCDEF, 0);
    tbl[7]  = mk(0,1,0,0,2'b01,1, 32'h4000, 0, 32'h00008001, 1, 4'hF, 0, 32'hFFFF8001, 0);
    tbl[8]  = mk(0,1,0,0,2'b11,1, 32'h4004, 0, 32'hCAFEF00D, 2, 4'hF, 0, 32'hCAFEF00D, 0);
    tbl[9]  = mk(1,1,0,0,2'b00,0, 32'h5000, 32'h11223344, 32'h99999999, 1, 4'hF, 32'h11223344, 0, 0);
    tbl[10] = mk(0,1,0,0,2'b00,0, 32'h6000, 0, 32'h55AA55AA, 64, 4'hF, 0, 32'h55AA55AA, 0);
    tbl[11] = mk(0,1,0,0,2'b01,0, 32'h3001, 0, 0, -1, 4'hF, 0, 0, 1);
    tbl[12] = mk(0,1,0,0,2'b00,0, 32'h7000, 0, 32'h12345678, 0, 4'hF, 0, 0, 1);

    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_bus", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata}, 0);
    chk("reset_status", {load_data, load_valid, bus_err, halted, pipe_en}, {32'h0, 4'b0001});
    rst_n = 1;
    @(negedge clk);

    // Ack outside BUSY must not start anything.
    dmem_ack = 1;
    repeat (3) @(negedge clk);
    chk("idle_ack_ignored", {dmem_req, load_valid, pipe_en, bus_err}, {4'b0010});
    dmem_ack = 0;

    // Random aligned accesses; bus_err must stay clear throughout.
    for (int i = 0; i < 40; i++) begin
      int sz;
      rv.mw = 1'($urandom); rv.mr = rv.mw ? 1'($urandom) : 1'b1;
      rv.sh = 1'($urandom); rv.sb = 1'($urandom); rv.ew = 2'($urandom); rv.es = 1'($urandom);
      rv.wdata = $urandom; rv.rdata = $urandom; rv.ack_n = int'($urandom_range(1, 4));
      sz = size_of(rv);
      rv.addr = ($urandom & ~32'h3) | 32'(($urandom_range(0, 3) / sz) * sz);
      rv = model(rv);
      run($sformatf("rand%0d", i), rv);
    end

    for (int i = 0; i < 13; i++) run($sformatf("vec%0d", i), tbl[i]);

    // Syscall beats a simultaneous load and is absorbing.
    Syscall_in = 1; MemToReg_in = 1; addr_in = 32'h8000;
    #1 chk("halt_decode_pipe_en", 64'(pipe_en), 64'(0));
    @(negedge clk);
    chk("halt_entry", {halted, dmem_req, pipe_en}, {3'b100});
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("halt_absorbing", {halted, dmem_req, pipe_en}, {3'b100});

    // Reset in the middle of a BUSY access.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    MemWrite_in = 1; addr_in = 32'h9000; wdata_in = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 64'(dmem_req), 64'(1));
    #2 rst_n = 0;
    #1 chk("reset_drops_req", {dmem_req, halted, bus_err, load_valid}, {4'b0000});
    clear_inputs();
    #1 chk("reset_idle_pipe_en", 64'(pipe_en), 64'(1));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_reset_idle", {dmem_req, pipe_en}, {2'b01});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register: takes the registered MEM-stage control bundle and ALU address/store data, and runs the data-memory transaction.
- Drives a req/ack data-memory bus and does byte/half lane steering on stores. Does load extraction with sign/zero extension.
- Produces pipe_en, the advance enable fed to the stall inputs of all pipeline registers. Latches Syscall as a halt.

Parameters:
- DATA_BITS, 32, data and address width; only 32 is supported.
- TIMEOUT_CYC, 64, BUSY cycles without dmem_ack before the access is abandoned with bus_err.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemWrite_in  in  1  store request
- MemToReg_in  in  1  load request
- Sh_in  in  1  halfword store
- Sb_in  in  1  byte store
- ExtrWord_in  in  2  load size: 00 word, 01 half, 10 byte, 11 treated as word
- ExtrSigned_in  in  1  1 = sign-extend load, 0 = zero-extend load
- Syscall_in  in  1  syscall in MEM stage
- addr_in  in  DATA_BITS  effective address (ALU result_1)
- wdata_in  in  DATA_BITS  store data (regfile_out2)
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_be  out  4  byte enables, little-endian
- dmem_addr  out  DATA_BITS  word address, addr_in with bits [1:0] forced to 00
- dmem_wdata  out  DATA_BITS  lane-replicated store data
- dmem_ack  in  1  bus completion; dmem_rdata valid when high
- dmem_rdata  in  DATA_BITS  read word
- load_data  out  DATA_BITS  extracted load result
- load_valid  out  1  load_data valid (DONE cycle only)
- pipe_en  out  1  1 = pipeline registers advance
- bus_err  out  1  sticky: misaligned access or timeout
- halted  out  1  sticky: syscall seen

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, load_valid, bus_err, halted = 0.
  - Timeout counter = 0.
  - pipe_en follows the IDLE rule.
  - Reset during BUSY drops dmem_req immediately; the bus tolerates an abandoned request.
- Inputs:
  - access = MemWrite_in | MemToReg_in.
  - MemWrite_in has priority: with both set the access is a store and load_valid stays 0.
- FSM states: IDLE, BUSY, DONE, HALT.
- pipe_en is combinational: 1 in IDLE when access=0 and Syscall_in=0, and 1 in DONE; 0 otherwise.
- IDLE:
  - Syscall_in=1 (priority over access) -> HALT, halted<=1.
  - access with misalignment -> DONE, bus_err<=1, load_data<=0, load_valid<=0, no bus request. Misaligned means halfword with addr_in[0]=1, or word with addr_in[1:0]!=0.
  - Aligned access -> BUSY. Register dmem_req<=1, dmem_we<=MemWrite_in, dmem_addr, dmem_be, dmem_wdata. Clear the counter.
- Store lanes:
  - Sb_in: be = 1<<addr[1:0], wdata = byte replicated 4x.
  - Sh_in (Sb_in=0): be = addr[1] ? 1100 : 0011, wdata = half replicated 2x.
  - Otherwise: be = 1111.
  - Sb_in has priority over Sh_in.
- Load lanes: be = 1111 for all loads; extraction happens on return.
- BUSY:
  - dmem_req and all bus outputs are held stable.
  - On a sampled dmem_ack=1 -> DONE, dmem_req<=0. For loads: load_data <= extract(dmem_rdata, addr[1:0], ExtrWord_in, ExtrSigned_in) and load_valid<=1.
  - Extraction selects the half by addr[1] or the byte by addr[1:0], then extends per ExtrSigned_in.
  - Counter increments each BUSY cycle without ack. At TIMEOUT_CYC-1 -> DONE, dmem_req<=0, bus_err<=1, load_data<=0, load_valid<=0.
  - Ack on the same cycle as the timeout: the ack wins and bus_err is not set.
- DONE:
  - One cycle with pipe_en=1. load_data/load_valid are presented to the MEM/WB register.
  - Inputs are ignored in DONE, so the departing instruction is never reissued.
  - Next state IDLE; load_valid<=0. load_data holds its value.
- Ack latency:
  - Minimum aligned access occupies 3 cycles: IDLE decode, BUSY (ack same cycle), DONE.
  - dmem_ack outside BUSY is ignored.
- HALT: absorbing until reset. pipe_en=0, dmem_req=0, halted=1.
- bus_err is sticky until reset; the pipeline continues after an error.

Test Plan:
- Aligned word store: addr=0x1004, wdata=0xDEADBEEF, MemWrite_in=1, ack after 2 BUSY cycles -> dmem_addr=0x1004, be=1111, we=1; pipe_en low 3 cycles, high 1.
- Byte store: addr=0x2003, wdata=0x000000A5, Sb_in=1 -> be=1000, dmem_wdata=0xA5A5A5A5.
- Signed byte load: addr=0x2002, rdata=0x12805634, ExtrWord=10, ExtrSigned=1 -> load_data=0xFFFFFF80, load_valid high exactly one cycle. Same access with ExtrSigned=0 -> 0x00000080.
- Unsigned half load: addr=0x3002, rdata=0xBEEF1234, ExtrWord=01, ExtrSigned=0 -> load_data=0x0000BEEF.
- Misaligned half load at 0x3001 -> no dmem_req, bus_err=1, DONE next cycle. Separately, no ack for TIMEOUT_CYC cycles -> bus_err=1, dmem_req drops. Ack on the timeout cycle -> bus_err stays 0.
- Syscall_in=1 together with MemToReg_in=1 -> HALT: pipe_en=0, no dmem_req, halted=1. rst_n low mid-BUSY -> dmem_req=0 immediately, state IDLE.
